// File: rtl/mult32x32_pkg.sv
// Shared constants, shift table and helpers for the fast 32x32 multiplier
// datapath and its control FSM.
package mult32x32_pkg;

    localparam int A_W    = 32;
    localparam int B_W    = 32;
    localparam int PROD_W = A_W + B_W;
    localparam int PP_W   = 24;

    typedef logic [2:0] shift_sel_t;

    localparam logic [5:0] SHIFT_AMT [0:5] = '{6'd0, 6'd8, 6'd16, 6'd24, 6'd32, 6'd40};

    // Place a partial product at its weight; selects 6 and 7 contribute nothing.
    function automatic logic [PROD_W-1:0] shift_pp(input logic [PP_W-1:0] pp,
                                                   input shift_sel_t sel);
        logic [PROD_W-1:0] ext;
        ext = {40'd0, pp};
        case (sel)
            3'd0:    shift_pp = ext << SHIFT_AMT[0];
            3'd1:    shift_pp = ext << SHIFT_AMT[1];
            3'd2:    shift_pp = ext << SHIFT_AMT[2];
            3'd3:    shift_pp = ext << SHIFT_AMT[3];
            3'd4:    shift_pp = ext << SHIFT_AMT[4];
            3'd5:    shift_pp = ext << SHIFT_AMT[5];
            default: shift_pp = 64'd0;
        endcase
    endfunction

    function automatic logic parity64(input logic [PROD_W-1:0] v);
        parity64 = ^v;
    endfunction

endpackage

// File: rtl/mult8x16.sv
// Combinational 8x16 -> 24-bit unsigned multiplier used once per cycle by
// the multiplier datapath.
module mult8x16 (
    input  logic [7:0]  x,
    input  logic [15:0] y,
    output logic [23:0] p
);

    assign p = {16'd0, x} * {8'd0, y};

endmodule

// File: rtl/mult32x32_fast_arith.sv
// Datapath of the fast 32x32 multiplier: operand capture, byte x word partial
// products, 64-bit accumulation and completion flag. Optional prod_parity
// output when MULT32X32_PARITY_EN is defined.
module mult32x32_fast_arith
    import mult32x32_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [A_W-1:0]    a,
    input  logic [B_W-1:0]    b,
    input  logic [1:0]        a_sel,
    input  logic              b_sel,
    input  logic [2:0]        shift_sel,
    input  logic              upd_prod,
    input  logic              clr_prod,
    input  logic              busy,
    output logic              a_msb_is_0,
    output logic              b_msw_is_0,
    output logic [PROD_W-1:0] product,
    output logic              prod_valid
`ifdef MULT32X32_PARITY_EN
    ,
    output logic              prod_parity
`endif
);

    logic [A_W-1:0]    a_r;
    logic [B_W-1:0]    b_r;
    logic              busy_d_r;
    logic [7:0]        a_byte_s;
    logic [15:0]       b_word_s;
    logic [PP_W-1:0]   pp_s;
    logic [PROD_W-1:0] product_nxt_s;
    logic              accept_s;

    assign accept_s   = start && !busy;
    assign a_msb_is_0 = (a_r[31:24] == 8'd0);
    assign b_msw_is_0 = (b_r[31:16] == 16'd0);

    // Operand capture; a start while busy is ignored so the ports may change freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= 32'd0;
            b_r <= 32'd0;
        end else if (accept_s) begin
            a_r <= a;
            b_r <= b;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    // Operand slice selection feeding the partial-product multiplier.
    always_comb begin
        a_byte_s = 8'd0;
        case (a_sel)
            2'd0:    a_byte_s = a_r[7:0];
            2'd1:    a_byte_s = a_r[15:8];
            2'd2:    a_byte_s = a_r[23:16];
            2'd3:    a_byte_s = a_r[31:24];
            default: a_byte_s = 8'd0;
        endcase
        if (b_sel) begin
            b_word_s = b_r[31:16];
        end else begin
            b_word_s = b_r[15:0];
        end
    end

    mult8x16 u_mult8x16 (
        .x (a_byte_s),
        .y (b_word_s),
        .p (pp_s)
    );

    // Next product value: clear beats accumulate; wraps mod 2^64.
    always_comb begin
        product_nxt_s = product;
        if (clr_prod) begin
            product_nxt_s = 64'd0;
        end else if (upd_prod) begin
            product_nxt_s = product + shift_pp(pp_s, shift_sel);
        end else begin
            product_nxt_s = product;
        end
    end

    // Product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product <= 64'd0;
        end else begin
            product <= product_nxt_s;
        end
    end

    // Completion flag: set on busy falling edge, a clear or accepted start wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_d_r   <= 1'b0;
            prod_valid <= 1'b0;
        end else begin
            busy_d_r <= busy;
            if (clr_prod || accept_s) begin
                prod_valid <= 1'b0;
            end else if (busy_d_r && !busy) begin
                prod_valid <= 1'b1;
            end else begin
                prod_valid <= prod_valid;
            end
        end
    end

`ifdef MULT32X32_PARITY_EN
    // Parity tracks the product register in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_parity <= 1'b0;
        end else begin
            prod_parity <= parity64(product_nxt_s);
        end
    end
`endif

endmodule
